// File: rtl/press_pkg.sv
// Shared types for the press event decoder: FSM state encoding and event codes.
package press_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SINGLE = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;
    localparam logic [1:0] EVT_TRIPLE = 2'b11;

endpackage

// File: rtl/press_event_decoder_if.sv
// Press input and classified-event handshake between debouncer, decoder and mode logic.
interface press_event_decoder_if;
    import press_pkg::*;

    logic       press_in;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_drop;

    modport master (
        input  press_in,
        input  evt_ready,
        output evt_valid,
        output evt_code,
        output evt_drop
    );

    modport slave (
        output press_in,
        output evt_ready,
        input  evt_valid,
        input  evt_code,
        input  evt_drop
    );

endinterface

// File: rtl/press_event_decoder_timer.sv
// Inter-press window timer: saturates at WINDOW_CYCLES-1 and flags expiry there.
module click_window_timer #(
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int TMR_W         = $clog2(WINDOW_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(WINDOW_CYCLES - 1);

    logic [TMR_W-1:0] count;

    assign expire = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (run && !expire) begin
            count <= count + TMR_W'(1);
        end
    end

endmodule

// File: rtl/press_event_decoder.sv
// Classifies debounced presses into single/double(/triple) click events.
// Triple detection is built only when PRESS_DEC_TRIPLE_EN is defined.
module press_event_decoder
    import press_pkg::*;
#(
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int TMR_W         = $clog2(WINDOW_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    press_event_decoder_if.master bus
);

    state_t     state;
    state_t     state_nxt;
    logic       gen;
    logic [1:0] gen_code;
    logic       tmr_clr;
    logic       tmr_run;
    logic       expire;

    assign tmr_run = (state != IDLE);

    click_window_timer #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .TMR_W         (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .run    (tmr_run),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A press always beats a coincident timeout.
    always_comb begin
        state_nxt = state;
        gen       = 1'b0;
        gen_code  = EVT_NONE;
        case (state)
            IDLE: begin
                if (bus.press_in) begin
                    state_nxt = WAIT1;
                end
            end
            WAIT1: begin
                if (bus.press_in) begin
`ifdef PRESS_DEC_TRIPLE_EN
                    state_nxt = WAIT2;
`else
                    gen       = 1'b1;
                    gen_code  = EVT_DOUBLE;
                    state_nxt = IDLE;
`endif
                end else if (expire) begin
                    gen       = 1'b1;
                    gen_code  = EVT_SINGLE;
                    state_nxt = IDLE;
                end
            end
`ifdef PRESS_DEC_TRIPLE_EN
            WAIT2: begin
                if (bus.press_in) begin
                    gen       = 1'b1;
                    gen_code  = EVT_TRIPLE;
                    state_nxt = IDLE;
                end else if (expire) begin
                    gen       = 1'b1;
                    gen_code  = EVT_DOUBLE;
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Restart the window on every press; hold it at zero whenever idle.
        tmr_clr = bus.press_in || (state_nxt == IDLE);
    end

    // Event holding register: never overwritten while pending and unaccepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.evt_valid <= 1'b0;
            bus.evt_code  <= EVT_NONE;
            bus.evt_drop  <= 1'b0;
        end else begin
            bus.evt_drop <= 1'b0;
            if (gen) begin
                if (!bus.evt_valid || bus.evt_ready) begin
                    bus.evt_valid <= 1'b1;
                    bus.evt_code  <= gen_code;
                end else begin
                    bus.evt_drop <= 1'b1;
                end
            end else if (bus.evt_valid && bus.evt_ready) begin
                bus.evt_valid <= 1'b0;
                bus.evt_code  <= EVT_NONE;
            end
        end
    end

endmodule

// File: tb/tb_press_event_decoder.sv
// Directed bench for press_event_decoder with WINDOW_CYCLES=8; follows PRESS_DEC_TRIPLE_EN.
module tb_press_event_decoder;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    press_event_decoder_if bus();

    press_event_decoder #(
        .WINDOW_CYCLES (W),
        .TMR_W         ($clog2(W))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle c begins just after a rising edge; press_in set in cycle c is sampled at its closing edge.
    task automatic run_case(input string tag, input int pa, input int pb, input int pc,
                            input int vcyc, input int code, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            bus.press_in = (c == pa) || (c == pb) || (c == pc);
            chk({tag, "_valid"}, int'(bus.evt_valid), (c == vcyc) ? 1 : 0);
            chk({tag, "_code"}, int'(bus.evt_code), (c == vcyc) ? code : 0);
            chk({tag, "_drop"}, int'(bus.evt_drop), 0);
            step();
        end
        bus.press_in = 1'b0;
    endtask

    initial begin
        bus.press_in  = 1'b0;
        bus.evt_ready = 1'b1;
        step();
        step();
        chk("rst_valid", int'(bus.evt_valid), 0);
        chk("rst_code", int'(bus.evt_code), 0);
        chk("rst_drop", int'(bus.evt_drop), 0);
        rst = 1'b0;
        step();

        run_case("single", 0, -1, -1, 9, 1, 14);
`ifdef PRESS_DEC_TRIPLE_EN
        run_case("triple", 0, 5, 10, 11, 3, 16);
        run_case("dbl_tmo", 0, 5, -1, 14, 2, 18);
        run_case("dbl_edge", 0, 8, -1, 17, 2, 21);
        run_case("dbl_b2b", 0, 1, -1, 10, 2, 14);
`else
        run_case("double", 0, 5, -1, 6, 2, 10);
        run_case("dbl_edge", 0, 8, -1, 9, 2, 13);
        run_case("dbl_b2b", 0, 1, -1, 2, 2, 6);
`endif

        // Backpressure: second single is discarded while the first waits.
        bus.evt_ready = 1'b0;
        for (int c = 0; c < 32; c++) begin
            bus.press_in = (c == 0) || (c == 20);
            chk("bp_valid", int'(bus.evt_valid), (c >= 9) ? 1 : 0);
            chk("bp_code", int'(bus.evt_code), (c >= 9) ? 1 : 0);
            chk("bp_drop", int'(bus.evt_drop), (c == 29) ? 1 : 0);
            step();
        end
        bus.press_in  = 1'b0;
        bus.evt_ready = 1'b1;
        chk("bp_hold_valid", int'(bus.evt_valid), 1);
        step();
        chk("bp_acc_valid", int'(bus.evt_valid), 0);
        chk("bp_acc_code", int'(bus.evt_code), 0);
        step();

        // Reset mid-window discards the partial count.
        for (int c = 0; c < 23; c++) begin
            bus.press_in = (c == 0) || (c == 10);
            rst = (c == 4);
            chk("rstmid_valid", int'(bus.evt_valid), (c == 19) ? 1 : 0);
            chk("rstmid_code", int'(bus.evt_code), (c == 19) ? 1 : 0);
            step();
        end
        rst = 1'b0;
        bus.press_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
